servo_pwm_capture: RTL and testbench

- Receive-side counterpart of the servo PWM generator: measures an incoming servo-style PWM waveform (pulse high time and period) on `clock`.
- Publishes the measurements as register-ready values, plus a 3-bit position code in the same encoding the generator consumes on `r2case`.
- Sits beside `regfile`; its outputs are wired into a read-only register slot, the way the ADC and `rest`/`active` inputs are.
- Used for loopback self-test of the servo output and for reading external RC/servo signals.

---
 rtl/servo_pwm_capture.sv | 124 ++++++++++++
 tb/tb_servo_pwm_capture.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high time and rise-to-rise period of pwm_in and publishes them
// with a quantized 3-bit position code, an in-range flag and a sticky timeout flag.
module servo_pwm_capture #(
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned MIN_HIGH = 25000,
    parameter int unsigned STEP     = 3125,
    parameter int unsigned MAX_HIGH = 50000,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [2:0]       pos_case,
    output logic             in_range,
    output logic             meas_valid,
    output logic             timeout,
    output logic [31:0]      data_word
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MinCnt     = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MaxCnt     = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] OneCnt     = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] hcnt_q, pcnt_q, idle_cnt_q;
    logic             rise, fall;
    logic [2:0]       pos_calc;
    logic             in_range_calc;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Comparator chain against MIN_HIGH + i*STEP replaces a divider.
    always_comb begin
        pos_calc      = 3'd0;
        in_range_calc = 1'b0;
        if (hcnt_q < MinCnt) begin
            pos_calc = 3'd0;
        end else if (hcnt_q > MaxCnt) begin
            pos_calc = 3'd7;
        end else begin
            in_range_calc = 1'b1;
            for (int unsigned i = 1; i <= 7; i++) begin
                if (hcnt_q >= CNT_W'(MIN_HIGH + i * STEP)) begin
                    pos_calc = pos_calc + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state_q    <= StIdle;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            idle_cnt_q <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            pos_case   <= 3'd0;
            in_range   <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            s1_q       <= pwm_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            meas_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        hcnt_q     <= OneCnt;
                        pcnt_q     <= OneCnt;
                        idle_cnt_q <= '0;
                        state_q    <= StHigh;
                    end else if (idle_cnt_q >= TimeoutCnt) begin
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + OneCnt;
                    end
                end
                StHigh, StLow: begin
                    // Timeout outranks a coincident rise; that rise is simply lost.
                    if (pcnt_q >= TimeoutCnt) begin
                        timeout    <= 1'b1;
                        idle_cnt_q <= '0;
                        state_q    <= StIdle;
                    end else if (state_q == StLow && rise) begin
                        high_cnt   <= hcnt_q;
                        period_cnt <= pcnt_q;
                        pos_case   <= pos_calc;
                        in_range   <= in_range_calc;
                        timeout    <= 1'b0;
                        meas_valid <= 1'b1;
                        hcnt_q     <= OneCnt;
                        pcnt_q     <= OneCnt;
                        state_q    <= StHigh;
                    end else begin
                        pcnt_q <= pcnt_q + OneCnt;
                        if (state_q == StHigh) begin
                            if (fall) begin
                                state_q <= StLow;
                            end else begin
                                hcnt_q <= hcnt_q + OneCnt;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_word = {timeout, in_range, 7'b0, pos_case, high_cnt[19:0]};

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Self-checking bench for servo_pwm_capture: randomized PWM stimulus against an edge-level
// behavioural model, plus literal spot checks of key results.
module tb_servo_pwm_capture;

    localparam int unsigned CNT_W    = 20;
    localparam int unsigned MIN_HIGH = 250;
    localparam int unsigned STEP     = 31;
    localparam int unsigned MAX_HIGH = 500;
    localparam int unsigned TIMEOUT  = 10000;

    logic             clock = 1'b0;
    logic             ctrl_reset_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic [2:0]       pos_case;
    logic             in_range, meas_valid, timeout;
    logic [31:0]      data_word;

    servo_pwm_capture #(
        .CNT_W   (CNT_W),
        .MIN_HIGH(MIN_HIGH),
        .STEP    (STEP),
        .MAX_HIGH(MAX_HIGH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .pos_case    (pos_case),
        .in_range    (in_range),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .data_word   (data_word)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail = 0;
    int valid_seen = 0;
    bit check_en = 1'b0;
    bit s6_mode = 1'b0;

    // Expected events: a publish or a reset, keyed by the clock edge that produces them.
    typedef struct {
        int at;
        bit is_rst;
        int hi;
        int per;
    } ev_t;
    ev_t q[$];

    bit prevlev = 1'b0;
    bit armed = 1'b0;
    int last_rise = 0;
    int cur_hi = 0;

    function automatic int pos_of(int h);
        int p;
        if (h < int'(MIN_HIGH)) return 0;
        if (h > int'(MAX_HIGH)) return 7;
        p = (h - int'(MIN_HIGH)) / int'(STEP);
        return (p > 7) ? 7 : p;
    endfunction

    function automatic bit inr_of(int h);
        return (h >= int'(MIN_HIGH)) && (h <= int'(MAX_HIGH));
    endfunction

    // Level sampled at edge e; a measurement is published two edges after the closing rise.
    task automatic model_edge(int e, bit rstn, bit lev);
        ev_t ev;
        if (!rstn) begin
            while (q.size() > 0 && q[q.size()-1].at >= e) q.pop_back();
            ev = '{at: e, is_rst: 1'b1, hi: 0, per: 0};
            q.push_back(ev);
            armed = 1'b0;
            prevlev = 1'b0;
        end else begin
            if (lev && !prevlev) begin
                if (armed && (e - last_rise) < int'(TIMEOUT)) begin
                    ev = '{at: e + 2, is_rst: 1'b0, hi: cur_hi, per: e - last_rise};
                    q.push_back(ev);
                end
                armed = !(armed && (e - last_rise) == int'(TIMEOUT));
                last_rise = e;
            end else if (!lev && prevlev) begin
                cur_hi = e - last_rise;
            end
            prevlev = lev;
        end
    endtask

    task automatic drive_edge(bit lev, bit rstn, int dly);
        int e;
        @(posedge clock);
        #1;
        e = cyc + 1;
        if (dly > 0) #(dly);
        pwm_in = lev;
        ctrl_reset_n = rstn;
        model_edge(e, rstn, lev);
    endtask

    // Sub-cycle offset for an asynchronous transition, kept clear of the sampling negedge.
    function automatic int rnd_dly();
        int d;
        d = $urandom_range(0, 6);
        if (d >= 4) d = d + 1;
        return d;
    endfunction

    task automatic seg(bit lev, int n, bit rnd);
        for (int i = 0; i < n; i++) drive_edge(lev, 1'b1, (i == 0 && rnd) ? rnd_dly() : 0);
    endtask

    task automatic pulse(int h, int p);
        seg(1'b1, h, 1'b1);
        seg(1'b0, p - h, 1'b1);
    endtask

    int j_cur = 0;
    task automatic pulse_jit(int h, int p);
        int g, jn;
        g = $urandom_range(0, 1);
        jn = $urandom_range(0, 1);
        seg(1'b1, h + g - j_cur, 1'b1);
        seg(1'b0, p - h - g + jn, 1'b1);
        j_cur = jn;
    endtask

    task automatic chk(string name, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [19:0] exp_h = '0, exp_p = '0;
    logic [2:0]  exp_pos = '0;
    logic        exp_inr = 1'b0;
    logic [30:0] exp_dw;
    bit          ev_v, ev_r, ok;
    ev_t         cev;

    always @(negedge clock) begin
        if (check_en) begin
            ev_v = 1'b0;
            ev_r = 1'b0;
            while (q.size() > 0 && q[0].at < cyc) begin
                cev = q.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL stale_event: got none expected event at %0d (cycle %0d)", cev.at, cyc);
            end
            if (q.size() > 0 && q[0].at == cyc) begin
                cev = q.pop_front();
                if (cev.is_rst) begin
                    ev_r = 1'b1;
                    exp_h = '0;
                    exp_p = '0;
                    exp_pos = '0;
                    exp_inr = 1'b0;
                end else begin
                    ev_v = 1'b1;
                    exp_h = 20'(cev.hi);
                    exp_p = 20'(cev.per);
                    exp_pos = 3'(pos_of(cev.hi));
                    exp_inr = inr_of(cev.hi);
                end
            end
            exp_dw = {exp_inr, 7'b0, exp_pos, exp_h};
            ok = (meas_valid === ev_v) && (high_cnt === exp_h) && (period_cnt === exp_p) &&
                 (pos_case === exp_pos) && (in_range === exp_inr) &&
                 (data_word[30:0] === exp_dw) &&
                 (!(ev_v || ev_r) || (timeout === 1'b0 && data_word[31] === 1'b0));
            n_assert++;
            if (!ok) begin
                n_fail++;
                $display("FAIL per_cycle@%0d: got v=%b h=%0d p=%0d pos=%0d inr=%b to=%b dw=%h expected v=%b h=%0d p=%0d pos=%0d inr=%b",
                         cyc, meas_valid, high_cnt, period_cnt, pos_case, in_range, timeout,
                         data_word, ev_v, exp_h, exp_p, exp_pos, exp_inr);
            end
            if (meas_valid === 1'b1) valid_seen++;
            if (ev_v && s6_mode) begin
                n_assert++;
                if (cev.hi < 374 || cev.hi > 376 || cev.per < 1199 || cev.per > 1201 ||
                    high_cnt < 374 || high_cnt > 376 || period_cnt < 1199 || period_cnt > 1201) begin
                    n_fail++;
                    $display("FAIL async_tolerance: got h=%0d p=%0d expected 375+-1 / 1200+-1",
                             high_cnt, period_cnt);
                end
            end
        end
    end

    int hs[7] = '{250, 280, 281, 470, 500, 240, 510};
    int ps[7] = '{0, 0, 1, 7, 7, 0, 7};
    int ir[7] = '{1, 1, 1, 1, 1, 0, 0};
    int vs;

    initial begin
        drive_edge(1'b0, 1'b0, 0);
        check_en = 1'b1;
        drive_edge(1'b0, 1'b0, 0);
        drive_edge(1'b0, 1'b0, 0);
        drive_edge(1'b0, 1'b1, 0);
        chk("reset_data_word", int'(data_word), 0);
        chk("reset_timeout", int'(timeout), 0);

        // Line held low after reset: idle timeout.
        seg(1'b0, 9000, 1'b0);
        chk("idle_no_timeout_yet", int'(timeout), 0);
        seg(1'b0, 1010, 1'b0);
        chk("idle_timeout", int'(timeout), 1);
        chk("idle_timeout_dw31", int'(data_word[31]), 1);
        chk("idle_no_valid", valid_seen, 0);

        pulse(300, 2000);
        chk("arm_no_valid", valid_seen, 0);
        pulse(375, 3000);
        chk("recover_timeout", int'(timeout), 0);
        chk("recover_high", int'(high_cnt), 300);
        chk("recover_period", int'(period_cnt), 2000);
        chk("recover_pos", int'(pos_case), 1);
        chk("recover_valid_count", valid_seen, 1);

        pulse(375, 3000);
        pulse(375, 3000);
        chk("mid_high", int'(high_cnt), 375);
        chk("mid_period", int'(period_cnt), 3000);
        chk("mid_pos", int'(pos_case), 4);
        chk("mid_inr", int'(in_range), 1);
        chk("mid_valid_count", valid_seen, 3);

        for (int i = 0; i < 7; i++) begin
            pulse(hs[i], 700);
            if (i > 0) begin
                chk("sweep_high", int'(high_cnt), hs[i-1]);
                chk("sweep_pos", int'(pos_case), ps[i-1]);
                chk("sweep_inr", int'(in_range), ir[i-1]);
            end
        end

        // Period longer than TIMEOUT: timeout in LOW, last results held.
        pulse(300, 10500);
        chk("low_timeout", int'(timeout), 1);
        chk("low_timeout_hold_high", int'(high_cnt), 510);
        chk("low_timeout_hold_pos", int'(pos_case), 7);
        chk("low_timeout_hold_inr", int'(in_range), 0);
        pulse(300, 700);
        pulse(320, 700);
        chk("rearm_timeout", int'(timeout), 0);
        chk("rearm_high", int'(high_cnt), 300);
        chk("rearm_period", int'(period_cnt), 700);

        // Reset mid-HIGH.
        seg(1'b1, 100, 1'b1);
        drive_edge(1'b1, 1'b0, 0);
        drive_edge(1'b1, 1'b1, 0);
        chk("rst_mid_high_high", int'(high_cnt), 0);
        chk("rst_mid_high_period", int'(period_cnt), 0);
        chk("rst_mid_high_dw", int'(data_word), 0);
        vs = valid_seen;
        seg(1'b1, 199, 1'b0);
        seg(1'b0, 500, 1'b0);
        chk("rst_one_rise_no_valid", valid_seen, vs);
        pulse(300, 700);
        chk("rst_two_rises_valid", valid_seen, vs + 1);
        chk("rst_two_rises_high", int'(high_cnt), 200);
        chk("rst_two_rises_period", int'(period_cnt), 700);

        // Asynchronous input with random phase and one-cycle jitter.
        pulse_jit(375, 1200);
        s6_mode = 1'b1;
        for (int i = 0; i < 11; i++) pulse_jit(375, 1200);
        seg(1'b1, 5, 1'b1);
        seg(1'b0, 20, 1'b0);
        chk("async_pos", int'(pos_case), 4);
        chk("events_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
